// File: rtl/board_io_bridge.sv
// Board-side I/O bridge: key conditioning, core reset stretch, registered video, board LEDs.
// Optional macro BOARD_IO_FRAME_LED_EN drives the LEDs from a vsync frame counter instead of the keys.
module board_io_bridge #(
  parameter int KEY_N       = 4,
  parameter int KEY_ACT_LOW = 1,
  parameter int DB_CYCLES   = 500000,
  parameter int RST_HOLD    = 16,
  parameter int RGB_IN_W    = 1,
  parameter int RGB_OUT_W   = 1,
  parameter int LED_N       = 8,
  parameter int FRAME_W     = 24
) (
  input  logic                   clk50mhz,
  input  logic                   rst_key,
  input  logic [KEY_N-1:0]       key_raw,
  output logic                   core_reset,
  output logic [KEY_N-1:0]       keys,
  output logic [KEY_N-1:0]       key_press,
  input  logic                   core_hsync,
  input  logic                   core_vsync,
  input  logic [3*RGB_IN_W-1:0]  core_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic [3*RGB_OUT_W-1:0] rgb,
  output logic [LED_N-1:0]       led
);

  localparam int CNT_W  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  if (DB_CYCLES < 2 || RST_HOLD < 1 || RGB_OUT_W < RGB_IN_W || FRAME_W < LED_N) begin : g_param_check
    $error("board_io_bridge: illegal parameter combination");
  end

  // Reset stretch: core_reset drops on the edge where the hold count reaches RST_HOLD.
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk50mhz) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_key) begin
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt   <= hold_cnt + 1'b1;
      core_reset <= (hold_cnt != HOLD_LAST);
    end else begin
      core_reset <= 1'b0;
    end
  end

  // Key path: normalise to pressed=1, 2-FF sync, then per-channel debounce.
  logic [KEY_N-1:0] key_norm;
  logic [KEY_N-1:0] sync1;
  logic [KEY_N-1:0] sync2;
  logic [CNT_W-1:0] db_cnt [KEY_N];

  assign key_norm = (KEY_ACT_LOW != 0) ? ~key_raw : key_raw;

  always_ff @(posedge clk50mhz) begin
    if (!rst_key) begin
      sync1     <= '0;
      sync2     <= '0;
      keys      <= '0;
      key_press <= '0;
      // NOTE: the counter array is small and must restart from zero, so it is reset explicitly.
      for (int i = 0; i < KEY_N; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= key_norm;
      sync2     <= sync1;
      key_press <= '0;
      for (int i = 0; i < KEY_N; i++) begin
        if (sync2[i] == keys[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          keys[i]      <= ~keys[i];
          key_press[i] <= ~keys[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Widen each colour by MSB-first replication of the input bits.
  logic [3*RGB_OUT_W-1:0] rgb_wide;

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    rgb_wide = '0;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < RGB_OUT_W; j++) begin
        rgb_wide[c*RGB_OUT_W + RGB_OUT_W-1-j] = core_rgb[c*RGB_IN_W + RGB_IN_W-1 - (j % RGB_IN_W)];
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (!rst_key) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= core_hsync;
      vsync <= core_vsync;
      rgb   <= rgb_wide;
    end
  end

`ifdef BOARD_IO_FRAME_LED_EN
  logic               vsync_prev;
  logic [FRAME_W-1:0] frame_cnt;

  always_ff @(posedge clk50mhz) begin
    if (!rst_key) begin
      vsync_prev <= 1'b1;
      frame_cnt  <= '0;
    end else begin
      vsync_prev <= vsync;
      if (core_reset)
        frame_cnt <= '0;
      else if (vsync_prev && !vsync)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign led = frame_cnt[FRAME_W-1 -: LED_N];
`else
  logic [LED_N+KEY_N-1:0] keys_ext;

  assign keys_ext = {{LED_N{1'b0}}, keys};
  assign led      = keys_ext[LED_N-1:0];
`endif

endmodule

// File: tb/tb_board_io_bridge.sv
// Self-checking bench for board_io_bridge: reset stretch, debounce, video widening, LEDs.
// Build with BOARD_IO_FRAME_LED_EN defined to exercise the frame-counter LED mode.
module tb_board_io_bridge;

  logic        clk50mhz;
  logic        rst_key;
  logic [3:0]  key_raw;
  logic        core_reset;
  logic [3:0]  keys;
  logic [3:0]  key_press;
  logic        core_hsync;
  logic        core_vsync;
  logic [2:0]  core_rgb;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  board_io_bridge #(
    .KEY_N(4), .KEY_ACT_LOW(1), .DB_CYCLES(8), .RST_HOLD(16),
    .RGB_IN_W(1), .RGB_OUT_W(4), .LED_N(8), .FRAME_W(8)
  ) dut (
    .clk50mhz(clk50mhz), .rst_key(rst_key), .key_raw(key_raw),
    .core_reset(core_reset), .keys(keys), .key_press(key_press),
    .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .led(led)
  );

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [2:0]  rgb_in;
    logic [11:0] rgb_exp;
  } vid_vec_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vid_exp_t;

  vid_vec_t vecs [8];
  vid_exp_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    rst_key = 1'b0;
    repeat (cycles) tick();
    rst_key = 1'b1;
  endtask

  initial begin
    vid_exp_t got;
    vid_exp_t exp;

    // {hsync, vsync, core_rgb, expected widened rgb}
    vecs[0] = '{1'b1, 1'b1, 3'b101, 12'hF0F};
    vecs[1] = '{1'b0, 1'b1, 3'b000, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 3'b111, 12'hFFF};
    vecs[3] = '{1'b0, 1'b0, 3'b010, 12'h0F0};
    vecs[4] = '{1'b1, 1'b1, 3'b100, 12'hF00};
    vecs[5] = '{1'b1, 1'b0, 3'b001, 12'h00F};
    vecs[6] = '{1'b0, 1'b1, 3'b110, 12'hFF0};
    vecs[7] = '{1'b1, 1'b1, 3'b011, 12'h0FF};

    rst_key    = 1'b0;
    key_raw    = 4'hF;
    core_hsync = 1'b0;
    core_vsync = 1'b0;
    core_rgb   = 3'b111;

    // Reset held for 3 cycles: outputs at their reset values despite active core inputs.
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_keys", keys, 0);
    check("rst_key_press", key_press, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb, 0);
    check("rst_led", led, 0);

    // Reset stretch: core_reset stays high until the 16th edge after release.
    core_hsync = 1'b1;
    core_vsync = 1'b1;
    core_rgb   = 3'b000;
    rst_key    = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("stretch_edge%0d", k), core_reset, (k < 16) ? 1 : 0);
    end
    repeat (3) tick();
    check("stretch_saturated", core_reset, 0);
    rst_key = 1'b0;
    tick();
    check("reassert_core_reset", core_reset, 1);
    rst_key = 1'b1;
    repeat (17) tick();
    check("stretch_again", core_reset, 0);

    // Press key 0: keys[0] rises exactly 10 edges later with a one-cycle pulse.
    key_raw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("press0_keys_e%0d", k), keys, (k >= 10) ? 4'b0001 : 4'b0000);
      check($sformatf("press0_pulse_e%0d", k), key_press, (k == 10) ? 4'b0001 : 4'b0000);
    end
`ifndef BOARD_IO_FRAME_LED_EN
    check("led_key0", led, 8'h01);
`endif

    // 5-cycle glitch on key 1 is rejected.
    key_raw[1] = 1'b0;
    repeat (5) tick();
    key_raw[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("glitch1_keys_e%0d", k), keys, 4'b0001);
      check($sformatf("glitch1_pulse_e%0d", k), key_press, 4'b0000);
    end

    // Release key 0: level falls after 10 edges, no pulse.
    key_raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("release0_keys_e%0d", k), keys, (k >= 10) ? 4'b0000 : 4'b0001);
      check($sformatf("release0_pulse_e%0d", k), key_press, 4'b0000);
    end

    // Simultaneous press on keys 0 and 2.
    key_raw = 4'b1010;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("dual_keys_e%0d", k), keys, (k >= 10) ? 4'b0101 : 4'b0000);
      check($sformatf("dual_pulse_e%0d", k), key_press, (k == 10) ? 4'b0101 : 4'b0000);
    end
`ifndef BOARD_IO_FRAME_LED_EN
    check("led_keys_0101", led, 8'h05);
`endif

    // Video path: table-driven, expected values queued on drive and popped one edge later.
    for (int v = 0; v < 8; v++) begin
      core_hsync = vecs[v].hs;
      core_vsync = vecs[v].vs;
      core_rgb   = vecs[v].rgb_in;
      sb_q.push_back('{vecs[v].hs, vecs[v].vs, vecs[v].rgb_exp});
      tick();
      got = '{hsync, vsync, rgb};
      exp = sb_q.pop_front();
      check($sformatf("vid%0d_hsync", v), got.hs, exp.hs);
      check($sformatf("vid%0d_vsync", v), got.vs, exp.vs);
      check($sformatf("vid%0d_rgb", v), got.rgb, exp.rgb);
    end
    check("vid_queue_drained", sb_q.size(), 0);
    core_vsync = 1'b1;

    // Reset mid-debounce on key 3 (count 5) restarts the full 2+DB_CYCLES latency.
    key_raw = 4'hF;
    pulse_reset(1);
    check("mid_reset_keys_clear", keys, 0);
    key_raw[3] = 1'b0;
    repeat (7) tick();
    check("mid_db_keys_still0", keys, 0);
    pulse_reset(1);
    check("mid_db_reset_keys", keys, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("redb3_keys_e%0d", k), keys, (k >= 10) ? 4'b1000 : 4'b0000);
      check($sformatf("redb3_pulse_e%0d", k), key_press, (k == 10) ? 4'b1000 : 4'b0000);
    end

`ifdef BOARD_IO_FRAME_LED_EN
    // Frame counter: 300 vsync falls wrap an 8-bit count to 44.
    core_vsync = 1'b1;
    pulse_reset(1);
    repeat (18) tick();
    check("frame_start_zero", led, 0);
    for (int f = 0; f < 300; f++) begin
      core_vsync = 1'b0;
      tick();
      core_vsync = 1'b1;
      tick();
    end
    repeat (2) tick();
    check("frame_wrap_44", led, 8'd44);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
